// File: rtl/osc_cfg_sequencer.sv
// osc_cfg_sequencer
//   Power-up programming sequencer for the I2C pixel oscillator. After reset it waits POWERUP_CYC
//   cycles. It then issues one byte-write per entry of a fixed {reg,data} table to the I2C
//   byte-write engine and checks each response. Once every entry has been answered it waits
//   SETTLE_CYC cycles and raises DDS_START.
//
//   Build option: define OSC_CFG_RETRY_EN to retry a NACKed entry up to MAX_RETRY extra times.
//   If that entry is still NACKed, the sequencer parks in a failure state. Without the macro a
//   NACKed entry is skipped, and CFG_FAIL is tied low.
//
// Ports
//   CLOCK_IN   system clock, rising edge
//   RESET_N    asynchronous active-low reset
//   CMD_VALID  write request to the I2C engine (held until accepted)
//   CMD_READY  engine accepts on CMD_VALID & CMD_READY
//   CMD_SLV    7-bit slave address
//   CMD_REG    register address of the current entry
//   CMD_DATA   data byte of the current entry
//   RSP_VALID  one-cycle pulse: transaction finished
//   RSP_NACK   qualifies RSP_VALID, 1 = a byte was NACKed
//   DDS_START  high once configuration is complete and settled
//   CFG_DONE   high once every entry has been responded to
//   CFG_FAIL   high when retries for an entry are exhausted
//   PROGRESS   index of the current entry, NUM_REGS when the table is complete
//   NACK_CNT   total NACK responses, saturating
module osc_cfg_sequencer #(
  parameter int unsigned POWERUP_CYC = 90000000,
  parameter int unsigned SETTLE_CYC  = 150000000,
  parameter int unsigned NUM_REGS    = 11,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h55,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLOCK_IN,
  input  logic       RESET_N,
  output logic       CMD_VALID,
  input  logic       CMD_READY,
  output logic [6:0] CMD_SLV,
  output logic [7:0] CMD_REG,
  output logic [7:0] CMD_DATA,
  input  logic       RSP_VALID,
  input  logic       RSP_NACK,
  output logic       DDS_START,
  output logic       CFG_DONE,
  output logic       CFG_FAIL,
  output logic [3:0] PROGRESS,
  output logic [7:0] NACK_CNT
);

  localparam logic [27:0] PwrLast    = 28'(POWERUP_CYC - 1);
  localparam logic [27:0] SettleLast = 28'(SETTLE_CYC - 1);
  localparam logic [4:0]  NumRegs    = 5'(NUM_REGS);

  if (NUM_REGS == 0 || NUM_REGS > 16 || MAX_RETRY > 255) begin : g_bad_params
    $error("osc_cfg_sequencer: NUM_REGS or MAX_RETRY out of range");
  end

  typedef enum logic [2:0] {
    StPwrWait,
    StIssue,
    StWaitRsp,
    StNext,
    StSettle,
    StRun,
    StFail
  } state_e;

  state_e      state_q, state_d;
  logic [27:0] cnt_q, cnt_d;
  logic [3:0]  progress_q, progress_d;
  logic [7:0]  nack_cnt_q, nack_cnt_d;
  logic        rsp_nack;
  logic        last_entry;

  // Oscillator register table, {reg, data}.
  function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
    logic [15:0] e;
    case (idx)
      4'd0:    e = 16'h8400;
      4'd1:    e = 16'h0033;
      4'd2:    e = 16'h05E4;
      4'd3:    e = 16'h06D1;
      4'd4:    e = 16'h07DF;
      4'd5:    e = 16'h0896;
      4'd6:    e = 16'h0908;
      4'd7:    e = 16'h0A1E;
      4'd8:    e = 16'h0B00;
      4'd9:    e = 16'h8401;
      4'd10:   e = 16'h8404;
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  // Responses only count while waiting for one; anything else is noise.
  assign rsp_nack   = (state_q == StWaitRsp) && RSP_VALID && RSP_NACK;
  // 5-bit compare so NUM_REGS = 16 still terminates.
  assign last_entry = ({1'b0, progress_q} + 5'd1) == NumRegs;

`ifdef OSC_CFG_RETRY_EN
  localparam int unsigned     RetryW   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  logic [RetryW-1:0] retry_q, retry_d;
  logic              retry_exhausted;

  assign retry_exhausted = (retry_q == RetryMax);
`endif

  // State register
  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StPwrWait;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StPwrWait: if (cnt_q == PwrLast) state_d = StIssue;
      StIssue:   if (CMD_READY) state_d = StWaitRsp;
      StWaitRsp: begin
        if (RSP_VALID) begin
          if (!RSP_NACK) begin
            state_d = StNext;
          end else begin
`ifdef OSC_CFG_RETRY_EN
            state_d = retry_exhausted ? StFail : StIssue;
`else
            // Entry abandoned, carry on with the rest of the table.
            state_d = StNext;
`endif
          end
        end
      end
      StNext:    state_d = last_entry ? StSettle : StIssue;
      StSettle:  if (cnt_q == SettleLast) state_d = StRun;
      StRun:     state_d = StRun;
      StFail:    state_d = StFail;
      default:   state_d = StPwrWait;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d      = cnt_q;
    progress_d = progress_q;
    nack_cnt_d = nack_cnt_q;
    case (state_q)
      StPwrWait: cnt_d = (cnt_q == PwrLast) ? 28'd0 : cnt_q + 28'd1;
      StNext: begin
        cnt_d      = 28'd0;
        progress_d = progress_q + 4'd1;
      end
      StSettle:  if (cnt_q != SettleLast) cnt_d = cnt_q + 28'd1;
      default:   cnt_d = cnt_q;
    endcase
    if (rsp_nack && (nack_cnt_q != 8'hFF)) nack_cnt_d = nack_cnt_q + 8'd1;
  end

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q      <= 28'd0;
      progress_q <= 4'd0;
      nack_cnt_q <= 8'd0;
    end else begin
      cnt_q      <= cnt_d;
      progress_q <= progress_d;
      nack_cnt_q <= nack_cnt_d;
    end
  end

`ifdef OSC_CFG_RETRY_EN
  always_comb begin
    retry_d = retry_q;
    if (state_q == StNext) begin
      retry_d = '0;
    end else if (rsp_nack && !retry_exhausted) begin
      retry_d = retry_q + RetryW'(1);
    end
  end

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  // Outputs. All are decoded from registered state, so reset clears them asynchronously.
  always_comb begin
    CMD_VALID           = (state_q == StIssue);
    CMD_SLV             = SLAVE_ADDR;
    {CMD_REG, CMD_DATA} = cfg_entry(progress_q);
    DDS_START           = (state_q == StRun);
    CFG_DONE            = (state_q == StSettle) || (state_q == StRun);
`ifdef OSC_CFG_RETRY_EN
    CFG_FAIL            = (state_q == StFail);
`else
    CFG_FAIL            = 1'b0;
`endif
    PROGRESS            = progress_q;
    NACK_CNT            = nack_cnt_q;
  end

endmodule

// File: tb/tb_osc_cfg_sequencer.sv
module tb_osc_cfg_sequencer;

  localparam int PwrCyc    = 10;
  localparam int SettleCyc = 20;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_slv;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_nack;
  logic       dds_start;
  logic       cfg_done;
  logic       cfg_fail;
  logic [3:0] progress;
  logic [7:0] nack_cnt;

  osc_cfg_sequencer #(
    .POWERUP_CYC(PwrCyc),
    .SETTLE_CYC (SettleCyc),
    .NUM_REGS   (11),
    .SLAVE_ADDR (7'h55),
    .MAX_RETRY  (3)
  ) dut (
    .CLOCK_IN (clk),
    .RESET_N  (rst_n),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .CMD_SLV  (cmd_slv),
    .CMD_REG  (cmd_reg),
    .CMD_DATA (cmd_data),
    .RSP_VALID(rsp_valid),
    .RSP_NACK (rsp_nack),
    .DDS_START(dds_start),
    .CFG_DONE (cfg_done),
    .CFG_FAIL (cfg_fail),
    .PROGRESS (progress),
    .NACK_CNT (nack_cnt)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] d;
  } wr_t;

  wr_t         exp_tbl [11];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] wlog [$];
  int          nack_left [16];
  int          ready_low_entry;
  int          ready_low_left;
  logic [15:0] hold_exp;
  bit          hold_started;
  int          stable_cnt;
  int          rsp_count;
  int          last_rsp_cyc;
  int          eng_entry;
  int          rsp_timer;
  bit          spur_req;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // I2C engine model: decisions made on the falling edge for the next rising edge.
  // Accepts when READY, answers 5 cycles after acceptance.
  task automatic engine();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmd_ready    = 1'b1;
        rsp_valid    = 1'b0;
        rsp_nack     = 1'b0;
        rsp_timer    = 0;
        eng_entry    = 0;
        hold_started = 1'b0;
      end else begin
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        if (rsp_timer > 0) begin
          rsp_timer--;
          if (rsp_timer == 0) begin
            rsp_valid    = 1'b1;
            rsp_count++;
            last_rsp_cyc = cyc + 1;
            if (eng_entry < 16 && nack_left[eng_entry] > 0) begin
              rsp_nack = 1'b1;
              nack_left[eng_entry]--;
`ifndef OSC_CFG_RETRY_EN
              eng_entry++;
`endif
            end else begin
              eng_entry++;
            end
          end
        end else if (spur_req) begin
          rsp_valid = 1'b1;
          rsp_nack  = 1'b1;
          spur_req  = 1'b0;
        end
        if (ready_low_left > 0 && eng_entry == ready_low_entry && (cmd_valid || hold_started)) begin
          hold_started = 1'b1;
          cmd_ready    = 1'b0;
          ready_low_left--;
          if (cmd_valid && {cmd_reg, cmd_data} == hold_exp) stable_cnt++;
        end else begin
          cmd_ready = 1'b1;
        end
        if (cmd_valid && cmd_ready) begin
          wlog.push_back({cmd_reg, cmd_data});
          rsp_timer = 5;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) nack_left[i] = 0;
    wlog.delete();
    ready_low_entry = 0;
    ready_low_left  = 0;
    hold_exp        = 16'h0000;
    stable_cnt      = 0;
    rsp_count       = 0;
    spur_req        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic pwr_timing(input string tag);
    repeat (PwrCyc - 1) tick();
    chk({tag, "_valid_before_powerup"}, cmd_valid, 1'b0);
    tick();
    chk({tag, "_valid_at_powerup"}, cmd_valid, 1'b1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (cfg_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, cfg_done, 1'b1);
  endtask

  task automatic wait_dds(input string name, input int budget, output int n);
    n = 0;
    while (dds_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, dds_start, 1'b1);
  endtask

  // Power-up wait with a spurious NACK pulse injected early; timing must be undisturbed.
  task automatic pwr_with_spur(input string tag);
    repeat (3) tick();
    spur_req = 1'b1;
    repeat (2) tick();
    chk({tag, "_spur_nack_cnt"}, nack_cnt, 8'd0);
    chk({tag, "_spur_valid"}, cmd_valid, 1'b0);
    chk({tag, "_spur_progress"}, progress, 4'd0);
    repeat (PwrCyc - 6) tick();
    chk({tag, "_valid_before_powerup"}, cmd_valid, 1'b0);
    tick();
    chk({tag, "_valid_at_powerup"}, cmd_valid, 1'b1);
  endtask

  task automatic run_tests();
    int          n;
    int          cnt;
    logic [15:0] got;

    exp_tbl = '{'{8'h84, 8'h00}, '{8'h00, 8'h33}, '{8'h05, 8'hE4}, '{8'h06, 8'hD1},
                '{8'h07, 8'hDF}, '{8'h08, 8'h96}, '{8'h09, 8'h08}, '{8'h0A, 8'h1E},
                '{8'h0B, 8'h00}, '{8'h84, 8'h01}, '{8'h84, 8'h04}};

    // Reset values
    repeat (2) tick();
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_dds_start", dds_start, 1'b0);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_cfg_fail", cfg_fail, 1'b0);
    chk("rst_progress", progress, 4'd0);
    chk("rst_nack_cnt", nack_cnt, 8'd0);
    chk("rst_cmd_reg", cmd_reg, 8'h84);
    chk("rst_cmd_data", cmd_data, 8'h00);
    chk("rst_cmd_slv", cmd_slv, 7'h55);

    // Run A: all ACK, READY held low 7 cycles at entry 3
    do_reset();
    ready_low_entry = 3;
    ready_low_left  = 7;
    hold_exp        = 16'h06D1;
    pwr_timing("a");
    chk("a_first_reg", cmd_reg, 8'h84);
    chk("a_first_data", cmd_data, 8'h00);
    wait_done("a_cfg_done", 500);
    chk("a_rsp_count_at_done", rsp_count, 11);
    chk("a_done_latency", cyc, last_rsp_cyc + 1);
    chk("a_dds_at_done", dds_start, 1'b0);
    chk("a_progress", progress, 4'd11);
    chk("a_nack_cnt", nack_cnt, 8'd0);
    chk("a_write_count", wlog.size(), 11);
    for (int i = 0; i < 11; i++) begin
      got = (i < wlog.size()) ? wlog[i] : 16'hxxxx;
      chk($sformatf("a_write%0d", i), got, {exp_tbl[i].r, exp_tbl[i].d});
    end
    chk("a_hold_stable_cycles", stable_cnt, 7);
    wait_dds("a_dds_start", 100, n);
    chk("a_dds_latency", n, SettleCyc);
    chk("a_done_sticky", cfg_done, 1'b1);
    chk("a_fail_low", cfg_fail, 1'b0);

    // Run B: spurious response during power-up, then a NACKed entry
    do_reset();
`ifdef OSC_CFG_RETRY_EN
    nack_left[4] = 2;
    pwr_with_spur("b");
    wait_done("b_cfg_done", 600);
    chk("b_nack_cnt", nack_cnt, 8'd2);
    chk("b_progress", progress, 4'd11);
    chk("b_write_count", wlog.size(), 13);
    cnt = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i] == 16'h07DF) cnt++;
    chk("b_entry4_issues", cnt, 3);
    wait_dds("b_dds_start", 100, n);
    chk("b_fail_low", cfg_fail, 1'b0);

    // Run C: entry 2 NACKed four times -> failure
    do_reset();
    nack_left[2] = 4;
    n = 0;
    while (cfg_fail !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk("c_cfg_fail", cfg_fail, 1'b1);
    chk("c_progress", progress, 4'd2);
    chk("c_nack_cnt", nack_cnt, 8'd4);
    chk("c_write_count", wlog.size(), 6);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cmd_valid) cnt++;
    end
    chk("c_no_valid_after_fail", cnt, 0);
    chk("c_dds_low", dds_start, 1'b0);
    chk("c_done_low", cfg_done, 1'b0);
    chk("c_fail_sticky", cfg_fail, 1'b1);
`else
    nack_left[0] = 1;
    pwr_with_spur("b");
    wait_done("b_cfg_done", 500);
    chk("b_nack_cnt", nack_cnt, 8'd1);
    chk("b_progress", progress, 4'd11);
    chk("b_write_count", wlog.size(), 11);
    got = (wlog.size() > 1) ? wlog[0] : 16'hxxxx;
    chk("b_write0", got, 16'h8400);
    got = (wlog.size() > 1) ? wlog[1] : 16'hxxxx;
    chk("b_write1_after_skip", got, 16'h0033);
    wait_dds("b_dds_start", 100, n);
    chk("b_fail_low", cfg_fail, 1'b0);
`endif

    // Run D: reset during settle, then reset while a request is pending
    do_reset();
    wait_done("d_cfg_done", 500);
    repeat (5) tick();
    chk("d_in_settle_dds", dds_start, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("d_async_done", cfg_done, 1'b0);
    chk("d_async_progress", progress, 4'd0);
    chk("d_async_reg", cmd_reg, 8'h84);
    chk("d_async_dds", dds_start, 1'b0);
    do_reset();
    ready_low_entry = 0;
    ready_low_left  = 1000;
    hold_exp        = 16'h8400;
    pwr_timing("d");
    repeat (4) tick();
    chk("d_hold_stable_cycles", stable_cnt, 4);
    chk("d_valid_held", cmd_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("d_async_valid_drop", cmd_valid, 1'b0);
    do_reset();
    n = 0;
    while (wlog.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    got = (wlog.size() > 0) ? wlog[0] : 16'hxxxx;
    chk("d_restart_entry0", got, 16'h8400);
    wait_done("d_cfg_done2", 500);
    wait_dds("d_dds_start", 100, n);
    chk("d_nack_cnt", nack_cnt, 8'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    cmd_ready       = 1'b1;
    rsp_valid       = 1'b0;
    rsp_nack        = 1'b0;
    ready_low_entry = 0;
    ready_low_left  = 0;
    hold_exp        = 16'h0000;
    hold_started    = 1'b0;
    stable_cnt      = 0;
    rsp_count       = 0;
    last_rsp_cyc    = 0;
    eng_entry       = 0;
    rsp_timer       = 0;
    spur_req        = 1'b0;
    for (int i = 0; i < 16; i++) nack_left[i] = 0;
    fork
      engine();
      run_tests();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
